execute_mdu: RTL
================

Name: execute_mdu

Overview:
- Parametrised multi-cycle multiply/divide execute unit for RV64M/RV32M, including the W-suffixed word ops.
- Sits beside the single-cycle ALU path in the execute stage. Takes operands through a valid/ready handshake and returns a registered result plus destination register index.
- Results are held until the downstream stage accepts them.
- Supports pipeline flush.

Parameters:
- XLEN, 64, datapath width. Legal values are 32 and 64. Word ops are illegal when XLEN=32.
- RIDX_W, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- flush  in  1  synchronous abort of the in-flight op.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- mdu_op  in  4  encoded as {word, funct3}:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU
  - 8 MULW, 12 DIVW, 13 DIVUW, 14 REMW, 15 REMUW
  - 9/10/11 illegal
- rs1_data  in  XLEN  operand A (multiplicand/dividend).
- rs2_data  in  XLEN  operand B (multiplier/divisor).
- rd_idx  in  RIDX_W  destination register.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  XLEN  result.
- out_rd_idx  out  RIDX_W  destination register carried with the result.
- busy  out  1  an op is in flight (state != IDLE).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - state = IDLE
  - out_valid = 0, out_data = 0, out_rd_idx = 0
  - busy = 0
  - in_ready = 1 from the first edge after reset releases. in_ready is combinational on state == IDLE.
- States: IDLE, CALC, FIX, DONE.
- Accept:
  - An op is accepted on the edge where in_valid & in_ready & !flush.
  - On that edge the unit latches op, rd_idx, operand magnitudes, result sign and quotient sign.
  - The iteration counter loads N = XLEN for full-width ops, 32 for word ops.
- Word ops:
  - Operands are taken from bits [31:0].
  - Operands are sign- or zero-extended per op (DIVUW/REMUW zero-extend).
  - The final result is sign-extended from bit 31 to XLEN.
- Multiply:
  - Radix-2 shift-add on unsigned magnitudes, one bit per CALC cycle, with a 2N-bit product register.
  - MUL/MULW return the low half. MULH/MULHSU/MULHU return the high XLEN bits.
  - Sign handling: MULH signed×signed, MULHSU signed×unsigned, MULHU unsigned.
- Divide:
  - Restoring divide on magnitudes, one quotient bit per CALC cycle.
  - Quotient is negated if the operand signs differ (signed ops).
  - Remainder takes the dividend's sign.
- Transitions:
  - IDLE→CALC on accept.
  - CALC→FIX when the counter reaches 0, after N iteration edges.
  - FIX→DONE after one edge. FIX applies sign correction, width selection and word sign-extension, and registers out_data.
  - DONE→IDLE on out_valid & out_ready.
- Latency: out_valid is high after edge N+1 following the accepting edge, i.e. 65 edges for 64-bit ops and 33 for word ops.
- Special cases: IDLE→DONE directly; out_valid is high after 1 edge.
  - Divide by zero: quotient = all ones (word: sign-extended 0xFFFFFFFF), remainder = dividend (word: sext of low 32).
  - Signed overflow (most-negative ÷ −1): quotient = dividend, remainder = 0.
  - Illegal op: out_data = 0.
- Output holding: in DONE, out_valid, out_data and out_rd_idx are held stable until out_ready.
- Back-to-back ops: in_ready is 0 in DONE, so no new op is accepted on the handshake edge. The next op is accepted one cycle later at the earliest.
- Flush:
  - Highest priority after reset.
  - Next state is IDLE and out_valid = 0.
  - out_data and out_rd_idx are not cleared.
  - A request presented with flush is not accepted.
  - An output handshake coinciding with flush is void.
- Reset mid-operation: reset behaves like flush and also clears out_data and out_rd_idx.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined:
  - Multiply ops use a single-cycle combinational 2XLEN-bit signed/unsigned product computed in CALC.
  - N is forced to 1 for multiplies, so multiply latency is 2 edges.
  - Divide behaviour is unchanged.
- Undefined: the iterative shift-add multiplier is used, with latency as stated in Behaviour.

Test Plan:
- MUL, rs1=0x0000_0000_0000_0007, rs2=0xFFFF_FFFF_FFFF_FFFD (−3), rd=5, out_ready=1 → out_valid after 65 edges, out_data=0xFFFF_FFFF_FFFF_FFEB, out_rd_idx=5, then in_ready=1 the next cycle.
- MULHU with rs1=rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULHSU with rs1=−1, rs2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW rs1=0x0000_0000_8000_0000, rs2=0xFFFF_FFFF_FFFF_FFFF → out_valid after 1 edge, out_data=0xFFFF_FFFF_8000_0000. REMW with the same operands → 0.
- DIVU rs2=0, rs1=0x1234 → out_data=0xFFFF_FFFF_FFFF_FFFF. REMU rs2=0 → 0x1234. Both have 1-edge latency.
- REM rs1=−7, rs2=2 with out_ready held 0 for 10 cycles → out_data=0xFFFF_FFFF_FFFF_FFFF (−1), out_valid and out_data stable throughout, busy=1 until the handshake.
- DIV accepted, flush pulsed at iteration 20 → IDLE next edge, out_valid never asserts. A new MULW 3×4 is accepted next cycle → 12 after 33 edges. Repeat with rst_n=0 mid-CALC → all outputs return to reset values.

Source files
------------

// File: rtl/execute_mdu.sv
// execute_mdu: multi-cycle RV64M/RV32M multiply/divide unit with valid/ready handshake and flush.
// Define MDU_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle product.
module execute_mdu #(
    parameter int XLEN   = 64,
    parameter int RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        mdu_op,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [RIDX_W-1:0] rd_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_data,
    output logic [RIDX_W-1:0] out_rd_idx,
    output logic              busy
);
    localparam int CW = $clog2(XLEN) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0] op_q, op_d;
    logic neg_q, neg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d, acc_q, acc_d, mul_step, div_step, prod;
    logic [XLEN-1:0] b_q, b_d, out_q, out_d;
    logic [RIDX_W-1:0] rd_q, rd_d;
    logic word, is_div, is_rem, a_sgn, b_sgn, a_neg, b_neg, illegal, div0, ovf, special;
    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, most_neg, spec_res, quo, rem, res;
    logic [XLEN:0] r_sh, r_sub;

    function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
        logic [XLEN+31:0] t;
        t = {{XLEN{v[31]}}, v};
        return t[XLEN-1:0];
    endfunction

    function automatic logic [XLEN-1:0] fin(input logic w, input logic [XLEN-1:0] v);
        return w ? sx(v[31:0]) : v;
    endfunction

    assign word     = mdu_op[3];
    assign is_div   = mdu_op[2];
    assign is_rem   = mdu_op[2] & mdu_op[1];
    assign a_sgn    = mdu_op[2] ? ~mdu_op[0] : ((mdu_op[1:0] == 2'd1) | (mdu_op[1:0] == 2'd2));
    assign b_sgn    = mdu_op[2] ? ~mdu_op[0] : (mdu_op[1:0] == 2'd1);
    assign a_ext    = word ? (a_sgn ? sx(rs1_data[31:0]) : XLEN'(rs1_data[31:0])) : rs1_data;
    assign b_ext    = word ? (b_sgn ? sx(rs2_data[31:0]) : XLEN'(rs2_data[31:0])) : rs2_data;
    assign a_neg    = a_sgn & a_ext[XLEN-1];
    assign b_neg    = b_sgn & b_ext[XLEN-1];
    assign a_mag    = a_neg ? -a_ext : a_ext;
    assign b_mag    = b_neg ? -b_ext : b_ext;
    assign illegal  = word & ((XLEN == 32) | (~mdu_op[2] & (mdu_op[1:0] != 2'd0)));
    assign most_neg = word ? sx(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
    assign div0     = is_div & (b_ext == '0);
    assign ovf      = is_div & ~mdu_op[0] & (a_ext == most_neg) & (&b_ext);
    assign special  = illegal | div0 | ovf;
    assign spec_res = illegal ? '0 : div0 ? (is_rem ? a_ext : '1) : (is_rem ? '0 : a_ext);

    // Restoring divide: acc holds {remainder, dividend/quotient}, one quotient bit per step.
    assign r_sh     = acc_q[2*XLEN-1:XLEN-1];
    assign r_sub    = r_sh - {1'b0, b_q};
    assign div_step = {r_sub[XLEN] ? r_sh[XLEN-1:0] : r_sub[XLEN-1:0], acc_q[XLEN-2:0], ~r_sub[XLEN]};
`ifdef MDU_FAST_MUL_EN
    assign mul_step = mcand_q * {{XLEN{1'b0}}, b_q};
`else
    assign mul_step = acc_q + (b_q[0] ? mcand_q : '0);
`endif
    assign prod = neg_q ? -acc_q : acc_q;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];
    assign res  = ~op_q[2] ? ((op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : op_q[1] ? (neg_q ? -rem : rem) : (neg_q ? -quo : quo);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        rd_d    = rd_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    state_d = special ? DONE : CALC;
                    op_d    = mdu_op;
                    neg_d   = is_rem ? a_neg : (a_neg ^ b_neg);
                    cnt_d   = word ? CW'(32) : CW'(XLEN);
`ifdef MDU_FAST_MUL_EN
                    if (!is_div) cnt_d = CW'(1);
`endif
                    mcand_d = {{XLEN{1'b0}}, a_mag};
                    b_d     = b_mag;
                    acc_d   = is_div ? {{XLEN{1'b0}}, word ? a_mag << (XLEN-32) : a_mag} : '0;
                    rd_d    = rd_idx;
                    if (special) out_d = fin(word, spec_res);
                end
                CALC: begin
                    acc_d   = op_q[2] ? div_step : mul_step;
                    mcand_d = mcand_q << 1;
                    b_d     = op_q[2] ? b_q : b_q >> 1;
                    cnt_d   = cnt_q - 1'b1;
                    state_d = (cnt_q == CW'(1)) ? FIX : CALC;
                end
                FIX: begin
                    out_d   = fin(op_q[3], res);
                    state_d = DONE;
                end
                DONE: if (out_ready) state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            mcand_q <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            rd_q    <= rd_d;
        end
    end

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign busy       = state_q != IDLE;
    assign out_data   = out_q;
    assign out_rd_idx = rd_q;
endmodule
